// File: rtl/fp_tree_pkg.sv
// fp_tree_pkg: types and constants shared by the fp32 vector loader and the
// tree adder it feeds.
//   FP_W        - operand width (IEEE-754 single)
//   N_LANES_DEF - default number of operands per tree-add vector
//   LAT_W       - width of the adder latency counter
//   fp32_t      - one fp32 operand
//   loader_state_t - loader FSM states
//   is_nan()    - quiet/signalling NaN detector for one fp32 word
package fp_tree_pkg;

  localparam int unsigned FP_W        = 32;
  localparam int unsigned N_LANES_DEF = 10;
  localparam int unsigned LAT_W       = 8;

  typedef logic [FP_W-1:0] fp32_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  // All-ones exponent with a nonzero mantissa; infinities are not NaN.
  function automatic logic is_nan(input fp32_t w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_vector_loader.sv
// fp_vector_loader: collects N_LANES fp32 words from a valid/ready stream into
// an operand vector, holds the tree-adder enable for ADD_LAT cycles, captures
// the resulting sum and offers it downstream with a valid/ready handshake.
//
// Optional feature: define FP_LOADER_NAN_CHECK_EN to flag any NaN operand
// accepted into the current vector on nan_seen; otherwise nan_seen is tied 0.
//
// Ports
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - upstream operand present
//   in_data    - fp32 operand
//   in_ready   - loader accepts a word this cycle (FILL only)
//   Array      - operand vector to the tree adder
//   start      - tree-adder enable level (RUN and DONE)
//   sum_in     - sum from the tree adder
//   sum_out    - captured sum
//   sum_valid  - sum_out holds a valid sum
//   sum_ready  - downstream accepts sum_out
//   nan_seen   - sticky NaN flag for the current vector
module fp_vector_loader
  import fp_tree_pkg::*;
#(
  parameter int unsigned N_LANES = N_LANES_DEF,
  parameter int unsigned ADD_LAT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  fp32_t                 in_data,
  output logic                  in_ready,
  output fp32_t [N_LANES-1:0]   Array,
  output logic                  start,
  input  fp32_t                 sum_in,
  output fp32_t                 sum_out,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic                  nan_seen
);

  localparam int unsigned CNT_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_LANES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ADD_LAT - 1);

  loader_state_t     state;
  logic [CNT_W-1:0]  cnt;
  logic [LAT_W-1:0]  lat;

  logic word_take;
  logic sum_take;

  assign word_take = in_valid && in_ready;
  assign sum_take  = sum_valid && sum_ready;

  // Loader FSM; in_ready is kept as a flop that mirrors state == FILL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      lat       <= '0;
      Array     <= '0;
      start     <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        FILL: begin
          if (word_take) begin
            Array[cnt] <= in_data;
            if (cnt == CNT_LAST) begin
              cnt      <= '0;
              lat      <= '0;
              start    <= 1'b1;
              in_ready <= 1'b0;
              state    <= RUN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        RUN: begin
          // lat == k-1 on the k-th edge after start rose.
          if (lat == LAT_LAST) begin
            sum_out   <= sum_in;
            sum_valid <= 1'b1;
            lat       <= '0;
            state     <= DONE;
          end else begin
            lat <= lat + LAT_W'(1);
          end
        end
        DONE: begin
          if (sum_take) begin
            sum_valid <= 1'b0;
            start     <= 1'b0;
            in_ready  <= 1'b1;
            state     <= FILL;
          end
        end
        default: begin
          state    <= FILL;
          cnt      <= '0;
          lat      <= '0;
          start    <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef FP_LOADER_NAN_CHECK_EN
  // Sticky per-vector NaN flag; cleared together with the sum handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_seen <= 1'b0;
    end else if (sum_take) begin
      nan_seen <= 1'b0;
    end else if (word_take && is_nan(in_data)) begin
      nan_seen <= 1'b1;
    end
  end
`else
  assign nan_seen = 1'b0;
`endif

endmodule

// File: tb/tb_fp_vector_loader.sv
// tb_fp_vector_loader: directed bench for fp_vector_loader. The stimulus
// process feeds vectors and pushes each vector's expected result into a
// queue; the monitor process samples on the falling edge, pops and compares
// whenever a new sum is presented, and checks handshake timing around it.
// A behavioural tree-adder model drives sum_in with the correct sum only in
// the single cycle the loader should sample it.
module tb_fp_vector_loader;

  localparam int N_LANES = 10;
  localparam int ADD_LAT = 8;

  localparam logic [31:0] SUM_A    = 32'h41B8FCD7;  // 23.123457
  localparam logic [31:0] SUM_ONES = 32'h41200000;  // 10.0
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] ONE      = 32'h3F800000;

  typedef struct {
    logic [31:0]                sum;
    logic [N_LANES-1:0][31:0]   arr;
    logic                       nan;
  } exp_t;

  logic                       clk;
  logic                       rst;
  logic                       in_valid;
  logic [31:0]                in_data;
  logic                       in_ready;
  logic [N_LANES-1:0][31:0]   arr_o;
  logic                       start;
  logic [31:0]                sum_in;
  logic [31:0]                sum_out;
  logic                       sum_valid;
  logic                       sum_ready;
  logic                       nan_seen;

  logic [31:0] vec_a [N_LANES] = '{
    32'h3f8ccccd, 32'h40066666, 32'h3fc00000, 32'h40400000, 32'h3f99999a,
    32'h40a00000, 32'h3f800000, 32'h40200000, 32'h3fcccccd, 32'h4083f35c
  };
  logic [31:0] vec_w [N_LANES];

  exp_t        exp_q [$];
  logic [31:0] cur_sum;
  bit          stim_done;
  int          total;
  int          bad;

  fp_vector_loader #(
    .N_LANES (N_LANES),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .Array     (arr_o),
    .start     (start),
    .sum_in    (sum_in),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .nan_seen  (nan_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Tree-adder model: sum valid only just before the ADD_LAT-th edge after start rose.
  initial begin : adder_model
    int run_cyc;
    run_cyc = 0;
    sum_in  = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (rst || !start) run_cyc = 0;
      else               run_cyc++;
      sum_in = (run_cyc == ADD_LAT) ? cur_sum : 32'hDEADBEEF;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic push_exp(input logic [31:0] sum, input logic nan);
    exp_t e;
    for (int i = 0; i < N_LANES; i++) e.arr[i] = vec_w[i];
    e.sum   = sum;
    e.nan   = nan;
    cur_sum = sum;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL send_word: in_ready stayed 0");
        $fatal(1, "timeout");
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic feed(input int count, input bit gap);
    for (int i = 0; i < count; i++) begin
      send_word(vec_w[i]);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sum_valid) break;
      n++;
      if (n > 200) begin
        $display("FAIL wait_valid: sum_valid never rose");
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic wait_release();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sum_valid && sum_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL wait_release: no sum handshake");
        $fatal(1, "timeout");
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    sum_ready = 1'b1;
    cur_sum   = '0;
    stim_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back fill.
    vec_w = vec_a;
    push_exp(SUM_A, 1'b0);
    feed(N_LANES, 1'b0);
    wait_release();

    // in_valid toggled every other cycle.
    push_exp(SUM_A, 1'b0);
    feed(N_LANES, 1'b1);
    wait_release();

    // Downstream stalls 20 cycles in DONE.
    sum_ready = 1'b0;
    push_exp(SUM_A, 1'b0);
    feed(N_LANES, 1'b0);
    wait_valid();
    repeat (20) @(posedge clk);
    #1 sum_ready = 1'b1;
    wait_release();

    // Reset after six words abandons the vector; then a vector of 1.0.
    feed(6, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N_LANES; i++) vec_w[i] = ONE;
    push_exp(SUM_ONES, 1'b0);
    feed(N_LANES, 1'b0);
    wait_release();

    // Third word is a quiet NaN.
    vec_w    = vec_a;
    vec_w[2] = QNAN;
`ifdef FP_LOADER_NAN_CHECK_EN
    push_exp(QNAN, 1'b1);
`else
    push_exp(QNAN, 1'b0);
`endif
    feed(N_LANES, 1'b0);
    wait_release();

    // A clean vector afterwards must not inherit the flag.
    vec_w = vec_a;
    push_exp(SUM_A, 1'b0);
    feed(N_LANES, 1'b1);
    wait_release();

    repeat (5) @(posedge clk);
    stim_done = 1'b1;
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    int          lat_cyc;
    int          word_cnt;
    bit          exp_start;
    bit          exp_release;
    bit          exp_nan;
    logic        prev_sv;
    logic        prev_start;
    logic [31:0] held;
    exp_t        e;
    total       = 0;
    bad         = 0;
    lat_cyc     = 0;
    word_cnt    = 0;
    exp_start   = 1'b0;
    exp_release = 1'b0;
    exp_nan     = 1'b0;
    prev_sv     = 1'b0;
    prev_start  = 1'b0;
    held        = '0;
    forever begin
      @(negedge clk);
      if (stim_done) begin
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      if (rst) begin
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_sum_valid", 32'(sum_valid), 32'd0);
        chk("rst_sum_out", sum_out, 32'd0);
        chk("rst_nan_seen", 32'(nan_seen), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_array_zero", 32'(arr_o != '0), 32'd0);
        word_cnt    = 0;
        exp_start   = 1'b0;
        exp_release = 1'b0;
        exp_nan     = 1'b0;
        prev_sv     = 1'b0;
        prev_start  = 1'b0;
        continue;
      end

      if (exp_start) begin
        chk("start_after_last_word", 32'(start), 32'd1);
        chk("in_ready_after_last_word", 32'(in_ready), 32'd0);
        exp_start = 1'b0;
      end
      if (exp_release) begin
        chk("release_sum_valid", 32'(sum_valid), 32'd0);
        chk("release_start", 32'(start), 32'd0);
        chk("release_nan_seen", 32'(nan_seen), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        exp_release = 1'b0;
      end
      if (exp_nan) begin
        chk("nan_seen_next_cycle", 32'(nan_seen), 32'd1);
        exp_nan = 1'b0;
      end

      if (start && !prev_start) lat_cyc = 0;
      else if (start)           lat_cyc++;

      if (sum_valid && !prev_sv) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sum: got %h with no vector outstanding", sum_out);
        end else begin
          e = exp_q.pop_front();
          chk("sum_out", sum_out, e.sum);
          chk("sum_latency", 32'(lat_cyc), 32'(ADD_LAT));
          chk("sum_nan_seen", 32'(nan_seen), 32'(e.nan));
          for (int i = 0; i < N_LANES; i++)
            chk($sformatf("array[%0d]", i), arr_o[i], e.arr[i]);
        end
        held = sum_out;
      end else if (sum_valid) begin
        chk("done_hold_sum_out", sum_out, held);
        chk("done_hold_start", 32'(start), 32'd1);
      end

      if (start) chk("busy_in_ready", 32'(in_ready), 32'd0);

      if (in_valid && in_ready) begin
`ifdef FP_LOADER_NAN_CHECK_EN
        if (in_data[30:23] == 8'hFF && in_data[22:0] != 23'd0) exp_nan = 1'b1;
`endif
        word_cnt++;
        if (word_cnt == N_LANES) begin
          word_cnt  = 0;
          exp_start = 1'b1;
        end
      end
      if (sum_valid && sum_ready) exp_release = 1'b1;

      prev_sv    = sum_valid;
      prev_start = start;
    end
  end

endmodule
